// File: rtl/mem_access_unit.sv
// Load/store/IO responder: one request at a time over a valid/ready word bus, one response pulse each.
// Latency: fault 1 cycle, store 2, load 3 with a zero-wait bus; req_ready low (stall) outside IDLE.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_io,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_sz,
  input  logic        req_sx,
  input  logic [4:0]  req_rd,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic        bus_io,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_fault
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [1:0]  a_lo;
  logic [1:0]  sz_q;
  logic        sx_q;
  logic [4:0]  rd_q;

  logic [3:0]  be_calc;
  logic        misalign;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
  logic [31:0] ld_ext;

  assign req_ready  = (state == S_IDLE);
  assign bus_valid  = (state == S_ADDR);
  assign resp_valid = (state == S_RESP);

  always_comb begin
    be_calc  = 4'b0000;
    misalign = 1'b0;
    case (req_sz)
      2'd0: be_calc = 4'b0001 << req_addr[1:0];
      2'd1: begin
        be_calc  = req_addr[1] ? 4'b1100 : 4'b0011;
        misalign = req_addr[0];
      end
      2'd2: begin
        be_calc  = 4'b1111;
        misalign = |req_addr[1:0];
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    ld_b   = bus_rdata[{a_lo, 3'b000} +: 8];
    ld_h   = bus_rdata[{a_lo[1], 4'b0000} +: 16];
    ld_ext = bus_rdata;
    case (sz_q)
      2'd0:    ld_ext = {{24{sx_q & ld_b[7]}}, ld_b};
      2'd1:    ld_ext = {{16{sx_q & ld_h[15]}}, ld_h};
      default: ld_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= 8'd0;
      a_lo       <= 2'd0;
      sz_q       <= 2'd0;
      sx_q       <= 1'b0;
      rd_q       <= 5'd0;
      bus_we     <= 1'b0;
      bus_io     <= 1'b0;
      bus_addr   <= 32'd0;
      bus_be     <= 4'd0;
      bus_wdata  <= 32'd0;
      resp_rd    <= 5'd0;
      resp_data  <= 32'd0;
      resp_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          bus_we    <= req_write;
          bus_io    <= req_io;
          bus_addr  <= {req_addr[31:2], 2'b00};
          bus_be    <= be_calc;
          bus_wdata <= req_wdata;
          a_lo      <= req_addr[1:0];
          sz_q      <= req_sz;
          sx_q      <= req_sx;
          rd_q      <= req_rd;
          cnt       <= 8'd0;
          if (misalign) begin
            state      <= S_RESP;
            resp_rd    <= req_rd;
            resp_data  <= 32'd0;
            resp_fault <= 1'b1;
          end else begin
            state <= S_ADDR;
          end
        end
        S_ADDR: begin
          // A handshake on the last counted cycle takes priority over the timeout.
          if (bus_ready) begin
            cnt <= 8'd0;
            if (bus_we) begin
              state      <= S_RESP;
              resp_rd    <= rd_q;
              resp_data  <= 32'd0;
              resp_fault <= 1'b0;
            end else begin
              state <= S_DATA;
            end
          end else if (cnt == CNT_LAST) begin
            state      <= S_RESP;
            resp_rd    <= rd_q;
            resp_data  <= 32'd0;
            resp_fault <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (bus_rvalid) begin
            state      <= S_RESP;
            resp_rd    <= rd_q;
            resp_data  <= ld_ext;
            resp_fault <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            state      <= S_RESP;
            resp_rd    <= rd_q;
            resp_data  <= 32'd0;
            resp_fault <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
